branch_cmp_arbiter: RTL

BRANCH_CMP_ARBITER -- requirements
Module: branch_cmp_arbiter

---
 rtl/branch_cmp_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/branch_cmp_arbiter.sv
// Two-requester branch comparator: one shared eq/lt/ltu unit, round-robin grant,
// three-state accept/compare/respond pipeline with flush and handshake backpressure.
module branch_cmp_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [2:0]      req0_funct3,
  input  logic [2:0]      req1_funct3,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic            resp_taken,
  output logic            resp_illegal,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Returns {illegal, taken} for an RV32I B-type funct3.
  function automatic logic [1:0] branch_eval(input logic [2:0] f3, input logic eq,
                                             input logic lt, input logic ltu);
    logic [1:0] r;
    case (f3)
      3'b000:  r = {1'b0, eq};
      3'b001:  r = {1'b0, ~eq};
      3'b100:  r = {1'b0, lt};
      3'b101:  r = {1'b0, ~lt};
      3'b110:  r = {1'b0, ltu};
      3'b111:  r = {1'b0, ~ltu};
      default: r = {1'b1, 1'b0};
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            id_q, id_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;

  logic            grant;
  logic            br_eq, br_lt, br_ltu;
  logic [1:0]      eval;

  // Shared comparator on the latched operands
  always_comb begin
    br_eq  = (rs1_q == rs2_q);
    br_lt  = ($signed(rs1_q) < $signed(rs2_q));
    br_ltu = (rs1_q < rs2_q);
    eval   = branch_eval(funct3_q, br_eq, br_lt, br_ltu);
  end

  // Round-robin pick: a lone requester wins, the pointer breaks ties
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ptr_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Next-state, latch and handshake logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    funct3_d   = funct3_q;
    taken_d    = taken_q;
    illegal_d  = illegal_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && !RST && (req0_valid || req1_valid)) begin
          req0_ready = ~grant;
          req1_ready = grant;
          id_d       = grant;
          rs1_d      = grant ? req1_rs1 : req0_rs1;
          rs2_d      = grant ? req1_rs2 : req0_rs2;
          funct3_d   = grant ? req1_funct3 : req0_funct3;
          state_d    = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        if (flush) begin
          state_d   = S_IDLE;
          rs1_d     = '0;
          rs2_d     = '0;
          funct3_d  = 3'b000;
          taken_d   = 1'b0;
          illegal_d = 1'b0;
        end else begin
          taken_d   = eval[0];
          illegal_d = eval[1];
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        // flush outranks the handshake, so the pointer stays put
        if (flush) begin
          state_d   = S_IDLE;
          rs1_d     = '0;
          rs2_d     = '0;
          funct3_d  = 3'b000;
          taken_d   = 1'b0;
          illegal_d = 1'b0;
        end else if (resp_ready) begin
          state_d = S_IDLE;
          ptr_d   = ~id_q;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      id_q      <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= 3'b000;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      funct3_q  <= funct3_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign resp_valid   = (state_q == S_RESP);
  assign resp_id      = resp_valid & id_q;
  assign resp_taken   = resp_valid & taken_q;
  assign resp_illegal = resp_valid & illegal_q;
  assign busy         = (state_q != S_IDLE);

endmodule
